div_32_seq: RTL and testbench
=============================

DIV_32_SEQ -- requirements
Module: div_32_seq

Interface
REQ-001 The block SHALL have no parameters; the data width is fixed at 32 bits.
REQ-002 clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-004 start  input  1  request pulse; accepted only when busy=0.
REQ-005 signed_op  input  1  1=signed divide (DIV), 0=unsigned divide (DIVU); captured with start.
REQ-006 S  input  32  dividend; captured on the accepting edge.
REQ-007 T  input  32  divisor; captured on the accepting edge.
REQ-008 busy  output  1  high while a division is in progress.
REQ-009 done  output  1  one-cycle pulse; Y_hi/Y_lo are valid in that cycle.
REQ-010 div_zero  output  1  set with done when the captured T==0; held until the next accepted start.
REQ-011 Y_hi  output  32  remainder (HI register convention).
REQ-012 Y_lo  output  32  quotient (LO register convention).

Function
REQ-013 The FSM SHALL have states IDLE, RUN, FIN; reset enters IDLE.
REQ-014 IDLE: start=1 captures S, T and signed_op, clears div_zero, and moves to RUN with the iteration count at 0; start=0 stays in IDLE.
REQ-015 The captured divisor equals zero: the FSM SHALL go directly to FIN on the next edge, with quotient 0xFFFFFFFF, remainder equal to the captured S, and div_zero=1.
REQ-016 RUN SHALL perform one restoring shift/subtract step per cycle on the magnitudes for exactly 32 cycles, then go to FIN.
REQ-017 FIN SHALL apply sign correction, update Y_hi/Y_lo, and pulse done for exactly one cycle, then return to IDLE.
REQ-018 Latency SHALL be 34 cycles from the accepting edge to the done cycle for a nonzero divisor, and 2 cycles for a zero divisor.
REQ-019 busy SHALL be 1 in RUN and FIN and 0 in IDLE.
REQ-020 start while busy=1 SHALL be ignored, with no effect on the operation in progress.
REQ-021 start in the same cycle as done SHALL be ignored; a new start is accepted from the following cycle.
REQ-022 Y_hi/Y_lo SHALL hold their last result until the next done.
REQ-023 Unsigned mode SHALL satisfy S = Y_lo*T + Y_hi with Y_hi < T.
REQ-024 Signed mode SHALL truncate the quotient toward zero, and the remainder SHALL take the sign of the dividend.
REQ-025 Signed 0x80000000 / 0xFFFFFFFF SHALL give Y_lo=0x80000000 and Y_hi=0.

Reset
REQ-026 reset=1 SHALL force IDLE and set busy=0, done=0, div_zero=0, Y_hi=0, Y_lo=0 on that edge, including mid-operation.
REQ-027 reset SHALL take priority over start in the same cycle.
REQ-028 An aborted division SHALL produce no done pulse.

Configuration
REQ-029 With DIV_32_SEQ_SIGNED_EN defined, signed_op SHALL be honored as in REQ-024 and REQ-025.
REQ-030 Without DIV_32_SEQ_SIGNED_EN, signed_op SHALL be ignored and all operations treated as unsigned; ports and latency are unchanged.

Verification
REQ-031 Unsigned 100/7, start at cycle 0 -> done at cycle 34, Y_lo=14, Y_hi=2, div_zero=0.
REQ-032 Unsigned 0xFFFFFFFF/1 -> Y_lo=0xFFFFFFFF, Y_hi=0; then 5/0 -> done 2 cycles after start, Y_lo=0xFFFFFFFF, Y_hi=5, div_zero=1.
REQ-033 Signed build: -7/2 -> Y_lo=0xFFFFFFFD, Y_hi=0xFFFFFFFF; 0x80000000/-1 -> Y_lo=0x80000000, Y_hi=0. Unsigned build, same -7/2 operands -> Y_lo=0x7FFFFFFC, Y_hi=1.
REQ-034 Start 100/7, pulse start with 9/3 at cycle 10 -> the second start is ignored; a single done at cycle 34 gives Y_lo=14, Y_hi=2.
REQ-035 Start 100/7, assert reset at cycle 15 -> all outputs 0 the next cycle and no done; a fresh 9/3 start then completes normally with Y_lo=3, Y_hi=0.

Source files
------------

// File: rtl/div_32_seq_if.sv
// Request/result bundle for the sequential 32-bit divider: the master drives
// start and the operands, the slave returns status and the HI/LO result.
interface div_32_seq_if;
    logic        start;
    logic        signed_op;
    logic [31:0] S;
    logic [31:0] T;
    logic        busy;
    logic        done;
    logic        div_zero;
    logic [31:0] Y_hi;
    logic [31:0] Y_lo;

    modport master (
        output start, signed_op, S, T,
        input  busy, done, div_zero, Y_hi, Y_lo
    );

    modport slave (
        input  start, signed_op, S, T,
        output busy, done, div_zero, Y_hi, Y_lo
    );
endinterface

// File: rtl/div_32_seq.sv
// Sequential 32-bit restoring divider: remainder on Y_hi, quotient on Y_lo.
// Define DIV_32_SEQ_SIGNED_EN to honour signed_op; otherwise every divide is unsigned.
module div_32_seq (
    input  logic         clk,
    input  logic         reset,
    div_32_seq_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

    state_t      state;
    state_t      state_next;
    logic [31:0] s_cap;
    logic [31:0] t_cap;
    logic [31:0] rem;
    logic [31:0] quo;
    logic [31:0] dvs;
    logic        sgn;
    logic [5:0]  count;
    logic        op_signed;
    logic        accept;
    logic        t_zero;
    logic [31:0] s_abs;
    logic [31:0] t_abs;
    logic [32:0] shifted;
    logic [32:0] diff;
    logic [31:0] q_fix;
    logic [31:0] r_fix;

`ifdef DIV_32_SEQ_SIGNED_EN
    assign op_signed = bus.signed_op;
`else
    logic unused_signed_op;
    assign unused_signed_op = bus.signed_op;
    assign op_signed        = 1'b0;
`endif

    // A start in the done cycle is ignored even though the FSM is already idle.
    assign accept  = (state == IDLE) && bus.start && !bus.done;
    assign t_zero  = (t_cap == 32'd0);
    assign s_abs   = (op_signed && bus.S[31]) ? -bus.S : bus.S;
    assign t_abs   = (op_signed && bus.T[31]) ? -bus.T : bus.T;
    assign shifted = {rem, quo[31]};
    assign diff    = shifted - {1'b0, dvs};
    assign q_fix   = (sgn && (s_cap[31] ^ t_cap[31])) ? -quo : quo;
    assign r_fix   = (sgn && s_cap[31]) ? -rem : rem;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = RUN;
            RUN:     if (t_zero || (count == 6'd32)) state_next = FIN;
            FIN:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        bus.busy = (state != IDLE);
    end

    // The iteration counter runs one past the last step so the nonzero path
    // reaches FIN on the 33rd edge and reports done on the 34th.
    always_ff @(posedge clk) begin
        if (reset) begin
            s_cap        <= 32'd0;
            t_cap        <= 32'd0;
            rem          <= 32'd0;
            quo          <= 32'd0;
            dvs          <= 32'd0;
            sgn          <= 1'b0;
            count        <= 6'd0;
            bus.done     <= 1'b0;
            bus.div_zero <= 1'b0;
            bus.Y_hi     <= 32'd0;
            bus.Y_lo     <= 32'd0;
        end else begin
            bus.done <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        s_cap        <= bus.S;
                        t_cap        <= bus.T;
                        sgn          <= op_signed;
                        bus.div_zero <= 1'b0;
                        count        <= 6'd0;
                        rem          <= 32'd0;
                        quo          <= s_abs;
                        dvs          <= t_abs;
                    end
                end
                RUN: begin
                    if (!t_zero && (count != 6'd32)) begin
                        count <= count + 6'd1;
                        if (!diff[32]) begin
                            rem <= diff[31:0];
                            quo <= {quo[30:0], 1'b1};
                        end else begin
                            rem <= shifted[31:0];
                            quo <= {quo[30:0], 1'b0};
                        end
                    end
                end
                FIN: begin
                    bus.done     <= 1'b1;
                    bus.div_zero <= t_zero;
                    if (t_zero) begin
                        bus.Y_lo <= 32'hFFFF_FFFF;
                        bus.Y_hi <= s_cap;
                    end else begin
                        bus.Y_lo <= q_fix;
                        bus.Y_hi <= r_fix;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_div_32_seq.sv
// Self-checking bench for div_32_seq: an arithmetic reference model predicts
// every output each cycle, and directed cases pin literal results.
module tb_div_32_seq;
    logic clk = 1'b0;
    logic reset;
    int   cyc = 0;
    int   checks = 0;
    int   passes = 0;
    bit   checking = 1'b0;

    div_32_seq_if ifc ();

    div_32_seq dut (
        .clk   (clk),
        .reset (reset),
        .bus   (ifc)
    );

    always #5 clk = ~clk;

    // Reference model state: what the outputs must be after each edge.
    logic        pending = 1'b0;
    int          doneAt = 0;
    logic [31:0] pendQ, pendR;
    logic        pendZ;
    logic        expDone = 1'b0;
    logic        expDz = 1'b0;
    logic [31:0] expHi = 32'd0;
    logic [31:0] expLo = 32'd0;

    function automatic void refDiv(input logic [31:0] s, input logic [31:0] t,
                                   input logic sg, output logic [31:0] q,
                                   output logic [31:0] r);
        longint a, b, qq, rr;
        if (t == 32'd0) begin
            q = 32'hFFFF_FFFF;
            r = s;
        end else if (sg) begin
            a  = $signed(s);
            b  = $signed(t);
            qq = a / b;
            rr = a % b;
            q  = qq[31:0];
            r  = rr[31:0];
        end else begin
            q = s / t;
            r = s % t;
        end
    endfunction

    always @(posedge clk) begin
        logic acc;
        logic effSigned;
        cyc = cyc + 1;
        if (reset) begin
            pending = 1'b0;
            expDone = 1'b0;
            expDz   = 1'b0;
            expHi   = 32'd0;
            expLo   = 32'd0;
        end else begin
            acc     = ifc.start && !pending && !expDone;
            expDone = 1'b0;
            if (pending && cyc == doneAt) begin
                expDone = 1'b1;
                expLo   = pendQ;
                expHi   = pendR;
                expDz   = pendZ;
                pending = 1'b0;
            end
            if (acc) begin
`ifdef DIV_32_SEQ_SIGNED_EN
                effSigned = ifc.signed_op;
`else
                effSigned = 1'b0;
`endif
                refDiv(ifc.S, ifc.T, effSigned, pendQ, pendR);
                pendZ   = (ifc.T == 32'd0);
                doneAt  = cyc + (pendZ ? 2 : 34);
                pending = 1'b1;
                expDz   = 1'b0;
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act,
                               input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)",
                      name, act, exp, cyc);
    endtask

    always @(negedge clk) begin
        if (checking) begin
            checkOutput("done", 32'(ifc.done), 32'(expDone));
            checkOutput("busy", 32'(ifc.busy), 32'(pending));
            checkOutput("div_zero", 32'(ifc.div_zero), 32'(expDz));
            checkOutput("Y_hi", ifc.Y_hi, expHi);
            checkOutput("Y_lo", ifc.Y_lo, expLo);
        end
    end

    // Waits (bounded) for done; optionally sprays ignored start pulses meanwhile.
    task automatic waitDone(input int acc, input bit junk, output int lat);
        bit seen = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (ifc.done) begin
                seen = 1'b1;
                break;
            end
            if (junk && $urandom_range(0, 7) == 0) begin
                ifc.start = 1'b1;
                ifc.S     = $urandom;
                ifc.T     = $urandom;
            end else begin
                ifc.start = 1'b0;
            end
            @(negedge clk);
        end
        ifc.start = 1'b0;
        if (!seen) checkOutput("done_timeout", 32'd0, 32'd1);
        lat = cyc - acc;
    endtask

    task automatic launch(input logic [31:0] s, input logic [31:0] t,
                          input logic sg, output int acc);
        @(negedge clk);
        ifc.S         = s;
        ifc.T         = t;
        ifc.signed_op = sg;
        ifc.start     = 1'b1;
        @(negedge clk);
        ifc.start = 1'b0;
        acc       = cyc;
    endtask

    task automatic applyStimulus(input logic [31:0] s, input logic [31:0] t,
                                 input logic sg, input bit junk, output int lat);
        int acc;
        launch(s, t, sg, acc);
        waitDone(acc, junk, lat);
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int lat;
        int acc;
        logic [31:0] s, t;
        reset         = 1'b1;
        ifc.start     = 1'b0;
        ifc.signed_op = 1'b0;
        ifc.S         = 32'd0;
        ifc.T         = 32'd0;
        repeat (2) @(negedge clk);
        checking = 1'b1;
        checkOutput("rst_busy", 32'(ifc.busy), 32'd0);
        checkOutput("rst_Y_lo", ifc.Y_lo, 32'd0);
        reset = 1'b0;

        applyStimulus(32'd100, 32'd7, 1'b0, 1'b0, lat);
        checkOutput("lat_100_7", 32'(lat), 32'd34);
        checkOutput("lo_100_7", ifc.Y_lo, 32'd14);
        checkOutput("hi_100_7", ifc.Y_hi, 32'd2);
        checkOutput("dz_100_7", 32'(ifc.div_zero), 32'd0);

        applyStimulus(32'hFFFF_FFFF, 32'd1, 1'b0, 1'b0, lat);
        checkOutput("lo_max_1", ifc.Y_lo, 32'hFFFF_FFFF);
        checkOutput("hi_max_1", ifc.Y_hi, 32'd0);

        applyStimulus(32'd5, 32'd0, 1'b0, 1'b0, lat);
        checkOutput("lat_5_0", 32'(lat), 32'd2);
        checkOutput("lo_5_0", ifc.Y_lo, 32'hFFFF_FFFF);
        checkOutput("hi_5_0", ifc.Y_hi, 32'd5);
        checkOutput("dz_5_0", 32'(ifc.div_zero), 32'd1);

        applyStimulus(32'hFFFF_FFF9, 32'd2, 1'b1, 1'b0, lat);
`ifdef DIV_32_SEQ_SIGNED_EN
        checkOutput("lo_m7_2", ifc.Y_lo, 32'hFFFF_FFFD);
        checkOutput("hi_m7_2", ifc.Y_hi, 32'hFFFF_FFFF);
        applyStimulus(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b0, lat);
        checkOutput("lo_min_m1", ifc.Y_lo, 32'h8000_0000);
        checkOutput("hi_min_m1", ifc.Y_hi, 32'd0);
`else
        checkOutput("lo_m7_2_u", ifc.Y_lo, 32'h7FFF_FFFC);
        checkOutput("hi_m7_2_u", ifc.Y_hi, 32'd1);
`endif

        // Start raised during the done cycle must not launch a new divide.
        ifc.S     = 32'd9;
        ifc.T     = 32'd3;
        ifc.start = 1'b1;
        @(negedge clk);
        ifc.start = 1'b0;
        checkOutput("start_in_done", 32'(ifc.busy), 32'd0);

        launch(32'd100, 32'd7, 1'b0, acc);
        repeat (9) @(negedge clk);
        ifc.S     = 32'd9;
        ifc.T     = 32'd3;
        ifc.start = 1'b1;
        @(negedge clk);
        ifc.start = 1'b0;
        waitDone(acc, 1'b0, lat);
        checkOutput("lat_busy_start", 32'(lat), 32'd34);
        checkOutput("lo_busy_start", ifc.Y_lo, 32'd14);
        checkOutput("hi_busy_start", ifc.Y_hi, 32'd2);

        launch(32'd100, 32'd7, 1'b0, acc);
        repeat (14) @(negedge clk);
        reset     = 1'b1;
        ifc.start = 1'b1;
        @(negedge clk);
        reset     = 1'b0;
        ifc.start = 1'b0;
        checkOutput("abort_busy", 32'(ifc.busy), 32'd0);
        checkOutput("abort_done", 32'(ifc.done), 32'd0);
        checkOutput("abort_Y_lo", ifc.Y_lo, 32'd0);
        checkOutput("abort_Y_hi", ifc.Y_hi, 32'd0);
        repeat (40) @(negedge clk);
        applyStimulus(32'd9, 32'd3, 1'b0, 1'b0, lat);
        checkOutput("lo_9_3", ifc.Y_lo, 32'd3);
        checkOutput("hi_9_3", ifc.Y_hi, 32'd0);

        for (int n = 0; n < 40; n++) begin
            s = $urandom;
            case ($urandom_range(0, 7))
                0:       t = 32'd0;
                1, 2:    t = 32'($urandom_range(1, 15));
                3:       t = 32'hFFFF_FFFF;
                default: t = $urandom;
            endcase
            applyStimulus(s, t, 1'($urandom_range(0, 1)), 1'b1, lat);
            checkOutput("lat_rand", 32'(lat), (t == 32'd0) ? 32'd2 : 32'd34);
        end

        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
